// File: rtl/p405s_strg_pkg.sv
// Shared types and helpers for the load/store string/multiple sequencer.
// Bit 0 of each big-endian architected field maps to the MSB of the packed vectors used here.
package p405s_strg_pkg;

  typedef enum logic [1:0] {
    OP_SCALAR  = 2'b00,
    OP_MULT    = 2'b01,
    OP_STR_IMM = 2'b10,
    OP_STR_IDX = 2'b11
  } op_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned MAX_STRG_BYTES = 128;
  localparam int unsigned WORD_BYTES     = 4;

  // Transfer size is the remaining count capped at one word.
  function automatic logic [2:0] xfer_size(input logic [7:0] cnt);
    return (cnt >= 8'(WORD_BYTES)) ? 3'(WORD_BYTES) : cnt[2:0];
  endfunction

  // Left-justified lanes: lane 0 is the MSB of the mask.
  function automatic logic [3:0] lane_mask(input logic [2:0] size);
    logic [3:0] m;
    case (size)
      3'd1:    m = 4'b1000;
      3'd2:    m = 4'b1100;
      3'd3:    m = 4'b1110;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/p405s_strg_init_cnt.sv
// Initial byte count for an accepted storage op; purely combinational.
// Result is at most MAX_STRG_BYTES (multiple with RT=0).
module p405s_strg_init_cnt
  import p405s_strg_pkg::*;
(
  input  logic [1:0] opType,
  input  logic [4:0] dcdRSRT,
  input  logic [4:0] dcdNB,
  input  logic [6:0] EXE_xerTBC,
  output logic [7:0] initCnt
);

  always_comb begin
    initCnt = '0;
    case (opType)
      OP_SCALAR:  initCnt = 8'(WORD_BYTES);
      OP_MULT:    initCnt = {6'd32 - {1'b0, dcdRSRT}, 2'b00};
      OP_STR_IMM: initCnt = (dcdNB == 5'd0) ? 8'd32 : {3'b000, dcdNB};
      OP_STR_IDX: initCnt = {1'b0, EXE_xerTBC};
      default:    initCnt = '0;
    endcase
  end

endmodule

// File: rtl/p405s_strg_seq.sv
// Storage sequencer: splits string/multiple ops into word-or-less transfers, one GPR each.
// First request one cycle after start; each transfer held until xferAck; flush/reset abandon.
module p405s_strg_seq
  import p405s_strg_pkg::*;
(
  input  logic       CB,
  input  logic       reset,
  input  logic       startVld,
  input  logic [1:0] opType,
  input  logic [4:0] dcdRSRT,
  input  logic [4:0] dcdNB,
  input  logic [6:0] EXE_xerTBC,
  input  logic       xferAck,
  input  logic       flush,
  output logic       busy,
  output logic       strgEnd,
  output logic [7:0] byteCount,
  output logic       xferReq,
  output logic [2:0] xferSize,
  output logic [3:0] laneEn,
  output logic [4:0] gprAddr,
  output logic       opDone
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic [2:0] size_q, size_d;
  logic [3:0] lane_q, lane_d;
  logic [4:0] gpr_q, gpr_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       end_q, end_d;
  logic [7:0] init_cnt;
  logic [7:0] rem;

  p405s_strg_init_cnt u_init_cnt (
    .opType     (opType),
    .dcdRSRT    (dcdRSRT),
    .dcdNB      (dcdNB),
    .EXE_xerTBC (EXE_xerTBC),
    .initCnt    (init_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    size_d  = size_q;
    lane_d  = lane_q;
    gpr_d   = gpr_q;
    done_d  = 1'b0;
    rem     = cnt_q - {5'b00000, size_q};

    if (flush) begin
      // Flush outranks any coincident ack or start.
      state_d = ST_IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      size_d  = '0;
      lane_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (startVld) begin
            gpr_d = dcdRSRT;
            cnt_d = init_cnt;
            if (init_cnt == 8'd0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_XFER;
              req_d   = 1'b1;
              size_d  = xfer_size(init_cnt);
              lane_d  = lane_mask(xfer_size(init_cnt));
            end
          end
        end
        ST_XFER: begin
          if (xferAck && req_q) begin
            cnt_d = rem;
            gpr_d = gpr_q + 5'd1;
            if (rem == 8'd0) begin
              state_d = ST_DONE;
              req_d   = 1'b0;
              size_d  = '0;
              lane_d  = '0;
              done_d  = 1'b1;
            end else begin
              size_d = xfer_size(rem);
              lane_d = lane_mask(xfer_size(rem));
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    end_d  = ~busy_d;
  end

  always_ff @(posedge CB or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      gpr_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      gpr_q   <= gpr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
    end
  end

  assign busy      = busy_q;
  assign strgEnd   = end_q;
  assign byteCount = cnt_q;
  assign xferReq   = req_q;
  assign xferSize  = size_q;
  assign laneEn    = lane_q;
  assign gprAddr   = gpr_q;
  assign opDone    = done_q;

endmodule

// File: doc/p405s_strg_seq.md
P405S_STRG_SEQ -- requirements
Module: p405s_strg_seq

Interface
REQ-001 SHALL have the following ports: CB, input, 1, core clock; all state updates on rising edge.
REQ-002 SHALL have the following ports: reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have the following ports: startVld, input, 1, decode issues a storage op this cycle.
REQ-004 SHALL have the following ports: opType[0:1], input, 2, operation type: 00 scalar word, 01 multiple, 10 string immediate, 11 string indexed.
REQ-005 SHALL have the following ports: dcdRSRT[0:4], input, 5, first GPR.
REQ-006 SHALL have the following ports: dcdNB[0:4], input, 5, string immediate byte count.
REQ-007 SHALL have the following ports: EXE_xerTBC[0:6], input, 7, XER byte count for string indexed.
REQ-008 SHALL have the following ports: xferAck, input, 1, data-side accepts the current transfer.
REQ-009 SHALL have the following ports: flush, input, 1, pipeline flush.
REQ-010 SHALL have the following ports: busy, output, 1, sequencer active.
REQ-011 SHALL have the following ports: strgEnd, output, 1, no storage op in progress.
REQ-012 SHALL have the following ports: byteCount[0:7], output, 8, bytes remaining.
REQ-013 SHALL have the following ports: xferReq, output, 1, transfer request.
REQ-014 SHALL have the following ports: xferSize[0:2], output, 3, bytes in the current transfer (1-4).
REQ-015 SHALL have the following ports: laneEn[0:3], output, 4, left-justified byte lanes.
REQ-016 SHALL have the following ports: gprAddr[0:4], output, 5, target GPR.
REQ-017 SHALL have the following ports: opDone, output, 1, one-cycle completion pulse.

Function
REQ-018 SHALL have the states IDLE, XFER and DONE; busy=1 in XFER and DONE; strgEnd = ~busy.
REQ-019 SHALL accept startVld only in IDLE; startVld while busy SHALL be ignored.
REQ-020 SHALL load the initial count on acceptance:
- scalar: 4.
- multiple: (32-RT)*4; RT=0 gives 128.
- string immediate: NB, with NB=0 giving 32.
- string indexed: TBC.
REQ-021 SHALL load gprAddr=dcdRSRT on acceptance.
REQ-022 SHALL enter XFER in cycle N+1 after start in cycle N when the count is nonzero, with xferReq=1 in N+1.
REQ-023 SHALL handle a zero count (string indexed, TBC=0) as follows:
- go to DONE with no xferReq.
- opDone=1 in N+1.
REQ-024 SHALL in XFER drive xferSize=min(4,byteCount) and set laneEn bits 0..xferSize-1.
REQ-025 SHALL hold xferReq, xferSize, laneEn and gprAddr stable until xferAck.
REQ-026 SHALL on xferAck in XFER update byteCount -= xferSize and gprAddr = (gprAddr+1) mod 32 (31 wraps to 0).
REQ-027 SHALL on xferAck with a resulting count of 0 go to DONE, drop xferReq and pulse opDone for exactly one cycle, then return to IDLE.
REQ-028 SHALL ignore xferAck when xferReq=0.
REQ-029 SHALL on flush in any state return to IDLE on the next edge:
- xferReq=0, byteCount=0, and no opDone.
- flush SHALL win over a simultaneous xferAck or startVld.
REQ-030 SHALL NOT accept startVld in DONE; a start is accepted in the cycle after DONE at the earliest.
REQ-031 SHALL perform all count arithmetic in 8 bits; byteCount never exceeds 128 and never underflows.

Reset
REQ-032 SHALL on reset assertion, independent of CB, force:
- state IDLE, busy=0, strgEnd=1.
- byteCount=0, xferReq=0, xferSize=0, laneEn=0.
- gprAddr=0, opDone=0.
REQ-033 SHALL on reset asserted mid-operation abandon the operation with no opDone and no xferReq.
REQ-034 SHALL accept startVld on the first edge after reset deasserts.

Structure
REQ-035 SHALL place the following in the shared package p405s_strg_pkg:
- opType encodings.
- state encoding.
- constants MAX_STRG_BYTES=128 and WORD_BYTES=4.
REQ-036 SHALL compute the initial count (REQ-020) in combinational sub-module p405s_strg_init_cnt, inputs opType/dcdRSRT/dcdNB/EXE_xerTBC, output 8-bit count.
REQ-037 SHALL register every output; no combinational path from xferAck to outputs.

Verification
REQ-038 SHALL verify: multiple, RT=29, ack every cycle -> count 12,8,4,0; gprAddr 29,30,31; three transfers of size 4; opDone after 3rd ack.
REQ-039 SHALL verify: string immediate, NB=7, RT=31 -> transfers sized 4 then 3; laneEn 1111 then 1110; gprAddr 31 then 0.
REQ-040 SHALL verify: string indexed, TBC=0 -> no xferReq; opDone one cycle after start; strgEnd=1 next cycle.
REQ-041 SHALL verify: multiple RT=0 -> initial count 128; 32 transfers; ack withheld 3 cycles mid-op holds all outputs stable.
REQ-042 SHALL verify: flush coincident with final xferAck -> IDLE, no opDone, byteCount=0; startVld while busy ignored.
REQ-043 SHALL verify: reset asserted mid-XFER between clock edges -> outputs at reset values immediately.
